// File: rtl/dpr_lanes.sv
// Single-clock true dual-port RAM with per-lane write enables and selectable read-during-write.
// Define DPR_CLEAR_EN to build the bulk clear engine (clr/busy); otherwise busy is tied low.

module dpr_lanes_lane #(
    parameter int BW  = 8,
    parameter int RDW = 0
) (
    input  logic          we_i,
    input  logic [BW-1:0] wd_i,
    input  logic [BW-1:0] rd_i,
    output logic [BW-1:0] q_o
);
    // Write-through only for the lanes this port is writing.
    assign q_o = ((RDW != 0) && we_i) ? wd_i : rd_i;
endmodule

module dpr_lanes #(
    parameter int           AW  = 14,
    parameter int           DW  = 16,
    parameter int           BW  = 8,
    parameter int           RDW = 0,
    parameter logic [DW-1:0] CV = '0,
    parameter string        FN  = ""
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ce1,
    input  logic [DW/BW-1:0]   we1,
    input  logic [AW-1:0]      a1,
    input  logic [DW-1:0]      d1,
    output logic [DW-1:0]      q1,
    input  logic               ce2,
    input  logic [DW/BW-1:0]   we2,
    input  logic [AW-1:0]      a2,
    input  logic [DW-1:0]      d2,
    output logic [DW-1:0]      q2,
    input  logic               clr,
    output logic               busy
);
    localparam int NL    = DW / BW;
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    logic          blk;
    logic          clr_wr;
    logic [AW-1:0] clr_cnt;
    logic [NL-1:0] wr1_en, wr2_en;
    logic [DW-1:0] rd1_w, rd2_w;
    logic [DW-1:0] q1_d, q2_d, q1_q, q2_q;

`ifdef DPR_CLEAR_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clr) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // The word addressed in the cycle reset arrives is still cleared; reset only stops the sweep.
    assign clr_wr  = (state_q == S_CLEAR);
    assign clr_cnt = cnt_q;
    assign blk     = busy_q;
    assign busy    = busy_q;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign clr_wr     = 1'b0;
    assign clr_cnt    = '0;
    assign blk        = 1'b0;
    assign busy       = 1'b0;
`endif

    assign wr1_en = (ce1 && !blk) ? we1 : '0;
    assign wr2_en = (ce2 && !blk) ? we2 : '0;

    // Reads sample the array before this edge's writes land: cross-port reads see old data.
    assign rd1_w = mem[a1];
    assign rd2_w = mem[a2];

    for (genvar g = 0; g < NL; g++) begin : g_lane
        dpr_lanes_lane #(.BW(BW), .RDW(RDW)) u_l1 (
            .we_i (wr1_en[g]),
            .wd_i (d1[g*BW +: BW]),
            .rd_i (rd1_w[g*BW +: BW]),
            .q_o  (q1_d[g*BW +: BW])
        );
        dpr_lanes_lane #(.BW(BW), .RDW(RDW)) u_l2 (
            .we_i (wr2_en[g]),
            .wd_i (d2[g*BW +: BW]),
            .rd_i (rd2_w[g*BW +: BW]),
            .q_o  (q2_d[g*BW +: BW])
        );
    end

    // Port 2 is written after port 1 so it wins lanes both ports enable on the same word.
    always_ff @(posedge clock) begin
        if (clr_wr) begin
            mem[clr_cnt] <= CV;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (wr1_en[i]) mem[a1][i*BW +: BW] <= d1[i*BW +: BW];
                if (wr2_en[i]) mem[a2][i*BW +: BW] <= d2[i*BW +: BW];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q1_q <= '0;
            q2_q <= '0;
        end else if (!blk) begin
            if (ce1) q1_q <= q1_d;
            if (ce2) q2_q <= q2_d;
        end
    end

    assign q1 = q1_q;
    assign q2 = q2_q;
endmodule

// File: tb/tb_dpr_lanes.sv
// Scoreboard bench for dpr_lanes: stimulus queues expected read data, a monitor pops and compares.
// Clear-engine scenarios run when DPR_CLEAR_EN is defined.

module tb_dpr_lanes;
    localparam int RDW_T = 0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce1 = 1'b0, ce2 = 1'b0, clr = 1'b0;
    logic [1:0]  we1 = '0, we2 = '0;
    logic [3:0]  a1 = '0, a2 = '0;
    logic [15:0] d1 = '0, d2 = '0;
    logic [15:0] q1, q2;
    logic        busy;

    logic        rdf1 = 1'b0, rdf2 = 1'b0;
    logic        chk1_q = 1'b0, chk2_q = 1'b0;
    logic [15:0] exp1 [$];
    logic [15:0] exp2 [$];
    int          n_chk = 0;
    int          n_fail = 0;

    dpr_lanes #(.AW(4), .DW(16), .BW(8), .RDW(RDW_T), .CV(16'hA5A5), .FN("")) dut (
        .clock(clock), .reset(reset),
        .ce1(ce1), .we1(we1), .a1(a1), .d1(d1), .q1(q1),
        .ce2(ce2), .we2(we2), .a2(a2), .d2(d2), .q2(q2),
        .clr(clr), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a read marked at one edge is compared at the following falling edge.
    always @(posedge clock) begin
        chk1_q <= rdf1;
        chk2_q <= rdf2;
    end

    always @(negedge clock) begin
        if (chk1_q) begin
            if (exp1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL q1 scoreboard empty: got %h", q1);
            end else check("q1", q1, exp1.pop_front());
        end
        if (chk2_q) begin
            if (exp2.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL q2 scoreboard empty: got %h", q2);
            end else check("q2", q2, exp2.pop_front());
        end
    end

    task automatic idle();
        ce1 = 0; we1 = '0; ce2 = 0; we2 = '0; rdf1 = 0; rdf2 = 0; clr = 0;
    endtask
    task automatic step();
        @(negedge clock);
        idle();
    endtask
    task automatic wr1(input logic [3:0] a, input logic [15:0] d, input logic [1:0] we);
        ce1 = 1; we1 = we; a1 = a; d1 = d;
    endtask
    task automatic wr2(input logic [3:0] a, input logic [15:0] d, input logic [1:0] we);
        ce2 = 1; we2 = we; a2 = a; d2 = d;
    endtask
    task automatic chk_p1(input logic [15:0] e);
        rdf1 = 1; exp1.push_back(e);
    endtask
    task automatic chk_p2(input logic [15:0] e);
        rdf2 = 1; exp2.push_back(e);
    endtask
    task automatic rd_p1(input logic [3:0] a, input logic [15:0] e);
        ce1 = 1; we1 = '0; a1 = a; chk_p1(e);
    endtask
    task automatic rd_p2(input logic [3:0] a, input logic [15:0] e);
        ce2 = 1; we2 = '0; a2 = a; chk_p2(e);
    endtask

    function automatic logic [15:0] abort_val(input int i);
        return (i < 6) ? 16'hA5A5 : 16'(16'h0100 + i);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        step(); step();
        check("reset q1", q1, 16'h0000);
        check("reset q2", q2, 16'h0000);
        check("reset busy", 16'(busy), 16'h0000);
        reset = 0;

        // byte-lane writes
        wr1(3, 16'h1234, 2'b11); step();
        wr1(3, 16'hFF00, 2'b10); step();
        rd_p2(3, 16'hFF34); rd_p1(3, 16'hFF34); step();

        // same-port read-during-write
        wr1(5, 16'h0000, 2'b11); step();
        wr1(5, 16'hBEEF, 2'b01); chk_p1((RDW_T != 0) ? 16'h00EF : 16'h0000); step();
        rd_p1(5, 16'h00EF); step();
        wr2(13, 16'h0000, 2'b11); step();
        wr2(13, 16'h5A5A, 2'b10); chk_p2((RDW_T != 0) ? 16'h5A00 : 16'h0000); step();
        rd_p2(13, 16'h5A00); step();

        // write/write collisions
        wr1(7, 16'h1111, 2'b11); wr2(7, 16'h2222, 2'b01); step();
        rd_p1(7, 16'h1122); step();
        wr1(8, 16'hAAAA, 2'b11); wr2(8, 16'hBBBB, 2'b11); step();
        wr1(10, 16'h3300, 2'b10); wr2(10, 16'h0044, 2'b01); step();
        rd_p1(8, 16'hBBBB); rd_p2(10, 16'h3344); step();

        // cross-port read of a word being written
        wr1(9, 16'h0001, 2'b11); step();
        wr1(9, 16'hCAFE, 2'b11); rd_p2(9, 16'h0001); step();
        rd_p2(9, 16'hCAFE); step();
        a2 = 3; chk_p2(16'hCAFE); step();

        // independent writes on both ports
        wr1(11, 16'h1010, 2'b11); wr2(12, 16'h2020, 2'b11); step();
        rd_p1(12, 16'h2020); rd_p2(11, 16'h1010); step();

`ifdef DPR_CLEAR_EN
        for (int i = 0; i < 16; i++) begin
            wr1(4'(i), 16'(16'h0100 + i), 2'b11); step();
        end
        rd_p1(15, 16'h010F); rd_p2(14, 16'h010E); step();

        // clear aborted by reset on its sixth cycle; reset also beats a coincident clr
        clr = 1; step();
        for (int k = 0; k < 5; k++) begin
            check("busy abort window", 16'(busy), 16'h0001);
            wr1((k == 1) ? 4'd12 : 4'd0, 16'hDEAD, 2'b11); chk_p1(16'h010F);
            ce2 = 1; a2 = 4'd4; chk_p2(16'h010E);
            step();
        end
        check("busy before reset", 16'(busy), 16'h0001);
        reset = 1; clr = 1; step();
        reset = 0;
        check("busy after abort", 16'(busy), 16'h0000);
        check("q1 after abort", q1, 16'h0000);
        check("q2 after abort", q2, 16'h0000);
        step();
        check("busy reset beats clr", 16'(busy), 16'h0000);
        for (int i = 0; i < 16; i += 2) begin
            rd_p1(4'(i), abort_val(i)); rd_p2(4'(i + 1), abort_val(i + 1)); step();
        end

        // full clear; clr mid-sweep must not restart it
        clr = 1; step();
        for (int k = 0; k < 16; k++) begin
            check("busy clear window", 16'(busy), 16'h0001);
            wr1(4'(k), 16'hDEAD, 2'b11);
            ce2 = 1; a2 = 4'd0; chk_p2(16'h010F);
            if (k == 8) clr = 1;
            step();
        end
        check("busy after clear", 16'(busy), 16'h0000);
        wr1(2, 16'h7777, 2'b11); step();
        for (int i = 0; i < 16; i += 2) begin
            rd_p1(4'(i), (i == 2) ? 16'h7777 : 16'hA5A5);
            rd_p2(4'(i + 1), 16'hA5A5);
            step();
        end
`else
        clr = 1; wr1(4, 16'h4444, 2'b11); step();
        check("busy tied low", 16'(busy), 16'h0000);
        rd_p1(4, 16'h4444); step();
        check("busy tied low 2", 16'(busy), 16'h0000);
`endif

        step(); step();
        check("q1 scoreboard drained", 16'(exp1.size()), 16'h0000);
        check("q2 scoreboard drained", 16'(exp2.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
